alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Bus-fed ALU sequencer: fetches operand B over a handshake bus,
// executes an immediate op and drives the result back.
module alu_sequencer #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] bus_in,
  input  logic         ready_in,
  output logic [3:0]   bus_req,
  output logic [W-1:0] bus_out,
  output logic [W-1:0] bus_oe,
  output logic         ready_out,
  output logic         carry,
  output logic         zero,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_FETCH, S_EXEC, S_DRIVE
  } state_t;

  state_t       state, state_d;
  logic [3:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic         pend;
  logic         accept, fin, fin_err;
  logic         cnt_clr, cnt_inc, tmo;
  logic         fetch_op, movi_op;

  logic [W:0]   sum, diff;
  logic [W-1:0] res;
  logic         res_c;

  assign fetch_op = (opcode >= 4'd1) && (opcode <= 4'd5);
  assign movi_op  = (opcode == 4'd6);
  assign tmo      = (TIMEOUT > 0) && (cnt == CW'(TLAST));

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    unique case (1'b1)
      (op_q == 4'd1): begin
        res   = sum[W-1:0];
        res_c = sum[W];
      end
      (op_q == 4'd2): begin
        res   = diff[W-1:0];
        res_c = diff[W];
      end
      (op_q == 4'd3): res = a_q & b_q;
      (op_q == 4'd4): res = a_q | b_q;
      (op_q == 4'd5): res = a_q ^ b_q;
      (op_q == 4'd6): res = a_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    bus_req = 4'b0000;
    unique case (state)
      S_IDLE: begin
        // pend delays the illegal/NOP completion by one cycle
        if (pend) begin
          fin     = 1'b1;
          fin_err = (op_q != 4'd0);
        end else if (start) begin
          accept = 1'b1;
          if (fetch_op) begin
            state_d = S_REQ;
            cnt_clr = 1'b1;
          end else if (movi_op) begin
            state_d = S_EXEC;
          end
        end
      end
      S_REQ: begin
        bus_req = 4'b0011;
        if (ready_in) begin
          state_d = S_FETCH;
          cnt_clr = 1'b1;
        end else if (tmo) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_FETCH: begin
        bus_req = 4'b0001;
        if (ready_in) begin
          state_d = S_EXEC;
        end else if (tmo) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_DRIVE;
        cnt_clr = 1'b1;
      end
      S_DRIVE: begin
        if (ready_in) begin
          state_d = S_IDLE;
          fin     = 1'b1;
        end else if (tmo) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt     <= '0;
      pend    <= 1'b0;
      bus_out <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_d;
      done  <= fin;
      if (accept) begin
        op_q <= opcode;
        a_q  <= imm;
        err  <= 1'b0;
        pend <= !(fetch_op || movi_op);
      end else if (fin) begin
        err  <= fin_err;
        pend <= 1'b0;
      end
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (state == S_FETCH && ready_in) b_q <= bus_in;
      if (state == S_EXEC) begin
        bus_out <= res;
        carry   <= res_c;
        zero    <= (res == '0);
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign ready_out = (state == S_DRIVE);
  assign bus_oe    = (state == S_DRIVE) ? '1 : '0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus
// timeout, async reset and wide-operand sequences.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] opcode;
  logic [3:0] imm, bus_in;
  logic       ready_in;
  logic [3:0] bus_req, bus_out, bus_oe;
  logic       ready_out, carry, zero, done, busy, err;

  logic       start8;
  logic [3:0] op8;
  logic [7:0] imm8, bus_in8;
  logic [3:0] bus_req8;
  logic [7:0] bus_out8, bus_oe8;
  logic       ready_out8, carry8, zero8, done8, busy8, err8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .imm(imm), .bus_in(bus_in),
    .ready_in(ready_in), .bus_req(bus_req),
    .bus_out(bus_out), .bus_oe(bus_oe),
    .ready_out(ready_out), .carry(carry),
    .zero(zero), .done(done), .busy(busy),
    .err(err)
  );

  alu_sequencer #(.W(8), .TIMEOUT(15)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .opcode(op8), .imm(imm8), .bus_in(bus_in8),
    .ready_in(1'b1), .bus_req(bus_req8),
    .bus_out(bus_out8), .bus_oe(bus_oe8),
    .ready_out(ready_out8), .carry(carry8),
    .zero(zero8), .done(done8), .busy(busy8),
    .err(err8)
  );

  typedef struct {
    logic [3:0] op;
    logic [3:0] imm;
    logic [3:0] b;
    logic [3:0] res;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic       saw3, saw1, bad;
    logic [3:0] drv;
    int         lat;
    saw3 = 1'b0;
    saw1 = 1'b0;
    bad  = 1'b0;
    drv  = 4'h0;
    lat  = 0;
    @(negedge clk);
    start    = 1'b1;
    opcode   = v.op;
    imm      = v.imm;
    bus_in   = v.b;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    opcode = 4'd5;
    imm    = ~v.imm;
    while (!done && lat < 40) begin
      if (bus_req == 4'b0011) saw3 = 1'b1;
      else if (bus_req == 4'b0001) saw1 = 1'b1;
      else if (bus_req != 4'b0000) bad = 1'b1;
      if (ready_out) begin
        drv = bus_out;
        if (bus_oe != 4'hF) bad = 1'b1;
      end else if (bus_oe != 4'h0) begin
        bad = 1'b1;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, v.lat);
    chk("err", err, v.e);
    chk("bus_out", bus_out, v.res);
    chk("carry", carry, v.c);
    chk("zero", zero, v.z);
    chk("busy_at_done", busy, 0);
    chk("bus_req_seq", {bad, saw3, saw1},
        (v.lat == 4) ? 3'b011 : 3'b000);
    if (v.lat >= 2) chk("drive_val", drv, v.res);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'd1, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0, 1'b0, 4};
    vecs[1]  = '{4'd2, 4'h3, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 4};
    vecs[2]  = '{4'd2, 4'h2, 4'h3, 4'hF, 1'b1, 1'b0, 1'b0, 4};
    vecs[3]  = '{4'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 4};
    vecs[4]  = '{4'd4, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0, 4};
    vecs[5]  = '{4'd5, 4'h6, 4'h6, 4'h0, 1'b0, 1'b1, 1'b0, 4};
    vecs[6]  = '{4'd6, 4'hA, 4'h3, 4'hA, 1'b0, 1'b0, 1'b0, 2};
    vecs[7]  = '{4'hF, 4'h2, 4'h2, 4'hA, 1'b0, 1'b0, 1'b1, 1};
    vecs[8]  = '{4'd0, 4'h1, 4'h1, 4'hA, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'd1, 4'h7, 4'h9, 4'h0, 1'b1, 1'b1, 1'b0, 4};
    vecs[10] = '{4'd7, 4'h4, 4'h4, 4'h0, 1'b1, 1'b1, 1'b1, 1};
    vecs[11] = '{4'd5, 4'h9, 4'h3, 4'hA, 1'b0, 1'b0, 1'b0, 4};
    vecs[12] = '{4'd1, 4'hF, 4'hF, 4'hE, 1'b1, 1'b0, 1'b0, 4};

    rst_n    = 1'b0;
    start    = 1'b0;
    opcode   = 4'd0;
    imm      = 4'd0;
    bus_in   = 4'd0;
    ready_in = 1'b0;
    start8   = 1'b0;
    op8      = 4'd0;
    imm8     = 8'd0;
    bus_in8  = 8'd0;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_bus_out", bus_out, 0);
    chk("rst_flags", {ready_out, carry, zero, done, busy, err}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // FETCH starved of ready_in until the wait counter expires
    @(negedge clk);
    start    = 1'b1;
    opcode   = 4'd1;
    imm      = 4'h3;
    bus_in   = 4'h1;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("to_req", bus_req, 4'b0011);
    @(posedge clk);
    #1;
    chk("to_fetch", bus_req, 4'b0001);
    ready_in = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("to_cycles", n, 15);
    chk("to_err", err, 1);
    chk("to_bus_req", bus_req, 0);
    chk("to_busy", busy, 0);
    chk("to_bus_oe", bus_oe, 0);
    chk("to_held", {bus_out, carry, zero}, {4'hE, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    chk("to_done_pulse", done, 0);

    // async reset while holding DRIVE
    @(negedge clk);
    start    = 1'b1;
    opcode   = 4'd6;
    imm      = 4'hA;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    ready_in = 1'b0;
    @(posedge clk);
    #1;
    chk("drv_ready_out", ready_out, 1);
    chk("drv_bus_oe", bus_oe, 4'hF);
    chk("drv_bus_out", bus_out, 4'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_bus_oe", bus_oe, 0);
    chk("ar_ready_out", ready_out, 0);
    chk("ar_state", {busy, carry, zero, err, done}, 0);
    chk("ar_bus_out", bus_out, 0);
    @(posedge clk);
    #1;
    chk("ar_no_done", done, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    ready_in = 1'b1;

    run_vec(vecs[0]);

    // wide instance carry out of the top bit
    @(negedge clk);
    start8  = 1'b1;
    op8     = 4'd1;
    imm8    = 8'hFF;
    bus_in8 = 8'h01;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_latency", n, 4);
    chk("w8_bus_out", bus_out8, 8'h00);
    chk("w8_carry", carry8, 1);
    chk("w8_zero", zero8, 1);
    chk("w8_err", err8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
